// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART TX frame arbiter.
// The optional launch timeout is enabled by defining TX_ARB_TIMEOUT_EN.
package uart_tx_arb_pkg;

  localparam int FRAME_W         = 128;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_LAUNCH      = 2'd1,
    ST_WAIT_ACTIVE = 2'd2,
    ST_WAIT_DONE   = 2'd3
  } tx_arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin priority picker: the search begins at 'pointer' and wraps,
// and the result is a one-hot winner (all zero when nothing requests).
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] winner
);

  logic found_s;
  logic hit_s;
  int   pos_s;

  // Walk the requesters from the pointer and keep only the first one asking.
  always_comb begin
    winner  = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    pos_s   = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      pos_s = int'(pointer) + off;
      pos_s = (pos_s >= NUM_REQ) ? (pos_s - NUM_REQ) : pos_s;
      for (int i = 0; i < NUM_REQ; i++) begin
        hit_s     = !found_s && (i == pos_s) && req[i];
        winner[i] = winner[i] | hit_s;
        found_s   = found_s | hit_s;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates 16-byte frame requests onto a single TX MAC launch interface.
// Define TX_ARB_TIMEOUT_EN to abort launches the MAC never acknowledges.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*FRAME_W-1:0] req_frame,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       start_tx_req,
  output logic [FRAME_W-1:0]         tx_frame,
  input  logic                       resp_active,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  tx_arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     idx_q, idx_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;

  logic [NUM_REQ-1:0]   win_s;
  logic [NUM_REQ-1:0]   gnt_s;
  logic [NUM_REQ-1:0]   done_s;
  logic [NUM_REQ-1:0]   idx_oh_s;
  logic [FRAME_W-1:0]   sel_frame_s;
  logic [PTR_W-1:0]     sel_idx_s;
  logic [PTR_W-1:0]     ptr_next_s;
  logic                 timeout_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req     (req),
    .pointer (ptr_q),
    .winner  (win_s)
  );

  // One-hot winner makes an AND-OR mux enough to pick its frame and index.
  always_comb begin
    sel_frame_s = '0;
    sel_idx_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_frame_s = sel_frame_s | (req_frame[i*FRAME_W +: FRAME_W] & {FRAME_W{win_s[i]}});
      sel_idx_s   = sel_idx_s | (PTR_W'(i) & {PTR_W{win_s[i]}});
    end
    ptr_next_s = (sel_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : (sel_idx_s + PTR_W'(1));
  end

  // Decode the granted index back to a one-hot done vector.
  always_comb begin
    idx_oh_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_oh_s[i] = (idx_q == PTR_W'(i));
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Cycles spent waiting for the MAC; cleared whenever not in WAIT_ACTIVE.
  always_comb begin
    if (state_q == ST_WAIT_ACTIVE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_s = (state_q == ST_WAIT_ACTIVE) && !resp_active &&
                     (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Arbitration FSM next-state logic; req is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    gnt_s   = '0;
    done_s  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_s   = win_s;
          idx_d   = sel_idx_s;
          frame_d = sel_frame_s;
          ptr_d   = ptr_next_s;
          state_d = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_ACTIVE;
      end
      ST_WAIT_ACTIVE: begin
        if (resp_active) begin
          state_d = ST_WAIT_DONE;
        end else if (timeout_s) begin
          done_s  = idx_oh_s;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_ACTIVE;
        end
      end
      ST_WAIT_DONE: begin
        if (!resp_active) begin
          done_s  = idx_oh_s;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, round-robin pointer, granted index and captured frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  // gnt is combinational from req, so it is forced low while reset is held.
  assign gnt          = rst_n ? gnt_s : '0;
  assign done         = done_s;
  assign err_timeout  = timeout_s;
  assign start_tx_req = (state_q == ST_LAUNCH);
  assign busy         = (state_q != ST_IDLE);
  assign tx_frame     = frame_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural TX MAC and a
// round-robin reference model; honours TX_ARB_TIMEOUT_EN like the design.
module tb_uart_tx_arbiter;

  localparam int N   = 3;
  localparam int TMO = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*128-1:0] req_frame = '0;
  logic             resp_active = 1'b0;
  logic [N-1:0]     gnt, done;
  logic             start_tx_req, busy, err_timeout;
  logic [127:0]     tx_frame;

  int          checks = 0;
  int          failures = 0;
  int          rr_last = N - 1;
  bit          mac_en = 1'b1;
  logic [7:0]  mac_bytes[$];

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_frame(req_frame),
    .gnt(gnt), .done(done), .start_tx_req(start_tx_req), .tx_frame(tx_frame),
    .resp_active(resp_active), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // TX MAC model: on a launch edge waits 1..3 cycles, then sends 16 bytes MSB first.
  initial begin : mac_model
    int   ms, wait_c, nb;
    logic sp;
    ms = 0; wait_c = 0; nb = 0; sp = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ms = 0;
        resp_active = 1'b0;
      end else begin
        case (ms)
          0: if (mac_en && start_tx_req && !sp) begin
               wait_c = $urandom_range(1, 3);
               ms = 1;
             end
          1: begin
               wait_c--;
               if (wait_c == 0) begin resp_active = 1'b1; nb = 0; ms = 2; end
             end
          default: begin
               mac_bytes.push_back(tx_frame[127-8*nb -: 8]);
               nb++;
               if (nb == 16) begin resp_active = 1'b0; ms = 0; end
             end
        endcase
      end
      sp = start_tx_req;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Reference: the first requester after the last granted one, wrapping.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input int last);
    logic [N-1:0] oh;
    int i;
    oh = '0;
    for (int k = 1; k <= N; k++) begin
      i = (last + k) % N;
      if (r[i] && oh == '0) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  function automatic int idx_of(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return 0;
  endfunction

  function automatic logic [127:0] rand_frame();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] mac_word();
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) if (k < mac_bytes.size()) w[127-8*k -: 8] = mac_bytes[k];
    return w;
  endfunction

  task automatic set_frame(input int i, input logic [127:0] f);
    req_frame[i*128 +: 128] = f;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rr_last = N - 1;
    mac_bytes.delete();
  endtask

  task automatic wait_gnt(input int budget, output logic [N-1:0] g, output int n);
    g = '0; n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (gnt !== '0) begin g = gnt; break; end
      n++;
    end
  endtask

  task automatic wait_done(input int budget, output logic [N-1:0] d, output logic e,
                           output logic prev_r, output logic [N-1:0] gseen);
    logic pr;
    int   n;
    d = '0; e = 1'b0; prev_r = 1'b0; gseen = '0; n = 0; pr = resp_active;
    while (n < budget) begin
      @(negedge clk);
      gseen = gseen | gnt;
      if (done !== '0) begin d = done; e = err_timeout; prev_r = pr; break; end
      pr = resp_active;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #1; rst_n = 1'b0;
    req = 3'b111;
    for (int i = 0; i < N; i++) set_frame(i, rand_frame());
    repeat (2) @(negedge clk);
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
    checks++; if (done !== 3'b000) begin failures++; $display("FAIL reset_done got=%b exp=000", done); end
    checks++; if (start_tx_req !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start_tx_req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (tx_frame !== 128'd0) begin failures++; $display("FAIL reset_frame got=%h exp=0", tx_frame); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    rr_last = N - 1;
    mac_bytes.delete();
  endtask

  task automatic test_single();
    logic [127:0] f;
    logic [N-1:0] g, d, exp, gs;
    logic         e, pr;
    int           n;
    f = 128'h000102030405060708090A0B0C0D0E0F;
    @(posedge clk); #1;
    set_frame(1, f); req = 3'b010;
    exp = rr_pick(req, rr_last);
    wait_gnt(10, g, n);
    checks++; if (g !== exp || n != 0) begin failures++; $display("FAIL single_gnt got=%b after %0d exp=%b after 0", g, n, exp); end
    rr_last = idx_of(exp);
    @(posedge clk); #1; req = '0;
    @(negedge clk);
    checks++; if (start_tx_req !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL single_launch start=%b busy=%b exp 1 1", start_tx_req, busy); end
    checks++; if (tx_frame !== f) begin failures++; $display("FAIL single_frame got=%h exp=%h", tx_frame, f); end
    @(negedge clk);
    checks++; if (start_tx_req !== 1'b0) begin failures++; $display("FAIL single_start_len got=%b exp=0", start_tx_req); end
    wait_done(60, d, e, pr, gs);
    checks++; if (d !== exp || e !== 1'b0) begin failures++; $display("FAIL single_done got=%b err=%b exp=%b err=0", d, e, exp); end
    checks++; if (pr !== 1'b1 || resp_active !== 1'b0) begin failures++; $display("FAIL single_done_timing prev=%b now=%b exp 1 0", pr, resp_active); end
    checks++; if (mac_bytes.size() != 16 || mac_word() !== f) begin failures++; $display("FAIL single_bytes n=%0d got=%h exp=%h", mac_bytes.size(), mac_word(), f); end
    mac_bytes.delete();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_contention();
    logic [127:0] fr[N];
    logic [N-1:0] g, d, exp, gs;
    logic [N-1:0] order[4];
    logic         e, pr;
    int           n, ix;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    apply_reset();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin fr[i] = rand_frame(); set_frame(i, fr[i]); end
    req = 3'b111;
    for (int it = 0; it < 4; it++) begin
      exp = rr_pick(req, rr_last);
      wait_gnt(10, g, n);
      checks++; if (g !== exp || g !== order[it]) begin failures++; $display("FAIL contention_gnt%0d got=%b exp=%b", it, g, order[it]); end
      if (it > 0) begin
        checks++; if (n != 0) begin failures++; $display("FAIL contention_regrant%0d idle_cycles=%0d exp=0", it, n); end
      end
      ix = idx_of(exp);
      rr_last = ix;
      if (it == 3) begin @(posedge clk); #1; req = '0; end
      @(negedge clk);
      checks++; if (start_tx_req !== 1'b1 || tx_frame !== fr[ix]) begin failures++; $display("FAIL contention_launch%0d start=%b frame=%h exp 1 %h", it, start_tx_req, tx_frame, fr[ix]); end
      @(negedge clk);
      checks++; if (start_tx_req !== 1'b0) begin failures++; $display("FAIL contention_start_len%0d got=%b exp=0", it, start_tx_req); end
      wait_done(60, d, e, pr, gs);
      checks++; if (d !== exp || gs !== '0) begin failures++; $display("FAIL contention_done%0d got=%b gnt_while_busy=%b exp=%b 000", it, d, gs, exp); end
      checks++; if (mac_word() !== fr[ix]) begin failures++; $display("FAIL contention_bytes%0d got=%h exp=%h", it, mac_word(), fr[ix]); end
      mac_bytes.delete();
    end
  endtask

  task automatic test_late_arrival();
    logic [127:0] f0, f2;
    logic [N-1:0] g, d, exp, gs;
    logic         e, pr;
    int           n;
    f0 = rand_frame(); f2 = rand_frame();
    @(posedge clk); #1;
    set_frame(0, f0); set_frame(2, f2); req = 3'b001;
    exp = rr_pick(req, rr_last);
    wait_gnt(10, g, n);
    checks++; if (g !== exp || g !== 3'b001) begin failures++; $display("FAIL late_gnt0 got=%b exp=001", g); end
    rr_last = idx_of(exp);
    @(posedge clk); #1; req = '0;
    @(negedge clk);
    @(posedge clk); #1; req[2] = 1'b1;
    wait_done(60, d, e, pr, gs);
    checks++; if (d !== 3'b001 || gs !== '0) begin failures++; $display("FAIL late_done0 got=%b gnt_while_busy=%b exp=001 000", d, gs); end
    checks++; if (mac_word() !== f0) begin failures++; $display("FAIL late_bytes0 got=%h exp=%h", mac_word(), f0); end
    mac_bytes.delete();
    exp = rr_pick(req, rr_last);
    wait_gnt(5, g, n);
    checks++; if (g !== exp || g !== 3'b100 || n != 0) begin failures++; $display("FAIL late_gnt2 got=%b after %0d exp=100 after 0", g, n); end
    rr_last = idx_of(exp);
    @(posedge clk); #1; req = '0;
    wait_done(60, d, e, pr, gs);
    checks++; if (d !== 3'b100) begin failures++; $display("FAIL late_done2 got=%b exp=100", d); end
    checks++; if (mac_word() !== f2) begin failures++; $display("FAIL late_bytes2 got=%h exp=%h", mac_word(), f2); end
    mac_bytes.delete();
  endtask

  task automatic test_frame_stability();
    logic [127:0] fa;
    logic [N-1:0] g, d, exp, gs;
    logic         e, pr;
    int           n;
    fa = rand_frame();
    @(posedge clk); #1;
    set_frame(0, fa); req = 3'b001;
    exp = rr_pick(req, rr_last);
    wait_gnt(10, g, n);
    checks++; if (g !== exp) begin failures++; $display("FAIL stable_gnt got=%b exp=%b", g, exp); end
    rr_last = idx_of(exp);
    @(posedge clk); #1;
    req = '0; set_frame(0, ~fa);
    @(negedge clk);
    checks++; if (tx_frame !== fa) begin failures++; $display("FAIL stable_frame got=%h exp=%h", tx_frame, fa); end
    wait_done(60, d, e, pr, gs);
    checks++; if (d !== exp) begin failures++; $display("FAIL stable_done got=%b exp=%b", d, exp); end
    checks++; if (mac_word() !== fa) begin failures++; $display("FAIL stable_bytes got=%h exp=%h", mac_word(), fa); end
    mac_bytes.delete();
    @(negedge clk);
    checks++; if (tx_frame !== fa) begin failures++; $display("FAIL stable_hold got=%h exp=%h", tx_frame, fa); end
  endtask

  task automatic test_random();
    logic [127:0] fexp;
    logic [N-1:0] g, d, exp, gs;
    logic         e, pr;
    int           n, ix;
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) set_frame(i, rand_frame());
      req = N'($urandom_range(1, 7));
      exp = rr_pick(req, rr_last);
      ix = idx_of(exp);
      fexp = req_frame[ix*128 +: 128];
      wait_gnt(10, g, n);
      checks++; if (g !== exp) begin failures++; $display("FAIL random_gnt%0d req=%b got=%b exp=%b", it, req, g, exp); end
      rr_last = ix;
      @(posedge clk); #1;
      req = '0;
      for (int i = 0; i < N; i++) set_frame(i, rand_frame());
      @(negedge clk);
      checks++; if (tx_frame !== fexp) begin failures++; $display("FAIL random_frame%0d got=%h exp=%h", it, tx_frame, fexp); end
      wait_done(60, d, e, pr, gs);
      checks++; if (d !== exp) begin failures++; $display("FAIL random_done%0d got=%b exp=%b", it, d, exp); end
      checks++; if (mac_word() !== fexp) begin failures++; $display("FAIL random_bytes%0d got=%h exp=%h", it, mac_word(), fexp); end
      mac_bytes.delete();
    end
  endtask

  task automatic test_timeout();
    logic [N-1:0] g, d, exp;
    logic         e;
    int           n, k, bad;
    mac_en = 1'b0;
    @(posedge clk); #1;
    set_frame(0, rand_frame()); req = 3'b001;
    exp = rr_pick(req, rr_last);
    wait_gnt(10, g, n);
    checks++; if (g !== exp) begin failures++; $display("FAIL timeout_gnt got=%b exp=%b", g, exp); end
    rr_last = idx_of(exp);
    @(posedge clk); #1; req = '0;
    @(negedge clk);
    checks++; if (start_tx_req !== 1'b1) begin failures++; $display("FAIL timeout_launch got=%b exp=1", start_tx_req); end
`ifdef TX_ARB_TIMEOUT_EN
    k = 0; d = '0; e = 1'b0;
    while (k < 40 && d === '0) begin
      @(negedge clk);
      k++;
      d = done; e = err_timeout;
    end
    checks++; if (k != TMO) begin failures++; $display("FAIL timeout_delay got=%0d exp=%0d", k, TMO); end
    checks++; if (d !== exp || e !== 1'b1) begin failures++; $display("FAIL timeout_pulse done=%b err=%b exp=%b 1", d, e, exp); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_after busy=%b err=%b exp 0 0", busy, err_timeout); end
`else
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b1 || err_timeout !== 1'b0 || done !== '0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL timeout_hang bad_cycles=%0d exp=0", bad); end
`endif
    apply_reset();
    mac_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    logic [127:0] f;
    logic [N-1:0] g, d, exp, gs, ds;
    logic         e, pr;
    int           n;
    f = rand_frame();
    @(posedge clk); #1;
    set_frame(0, f); req = 3'b001;
    exp = rr_pick(req, rr_last);
    wait_gnt(10, g, n);
    checks++; if (g !== exp) begin failures++; $display("FAIL rstmid_gnt got=%b exp=%b", g, exp); end
    @(posedge clk); #1; req = '0;
    n = 0;
    while (n < 10 && resp_active !== 1'b1) begin @(negedge clk); n++; end
    checks++; if (resp_active !== 1'b1) begin failures++; $display("FAIL rstmid_mac_start got=%b exp=1", resp_active); end
    repeat (3) @(negedge clk);
    #2; rst_n = 1'b0; req = 3'b011;
    #1;
    checks++; if (gnt !== '0 || done !== '0) begin failures++; $display("FAIL rstmid_gnt_done gnt=%b done=%b exp 000 000", gnt, done); end
    checks++; if (start_tx_req !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl start=%b busy=%b err=%b exp 0 0 0", start_tx_req, busy, err_timeout); end
    checks++; if (tx_frame !== 128'd0) begin failures++; $display("FAIL rstmid_frame got=%h exp=0", tx_frame); end
    ds = '0;
    repeat (3) begin @(negedge clk); ds = ds | done; end
    checks++; if (ds !== '0) begin failures++; $display("FAIL rstmid_no_done got=%b exp=000", ds); end
    rst_n = 1'b1;
    rr_last = N - 1;
    exp = rr_pick(req, rr_last);
    #1;
    checks++; if (gnt !== exp || gnt !== 3'b001) begin failures++; $display("FAIL rstmid_first_gnt got=%b exp=001", gnt); end
    rr_last = idx_of(exp);
    @(posedge clk); #1; req = '0;
    mac_bytes.delete();
    @(negedge clk);
    checks++; if (tx_frame !== f) begin failures++; $display("FAIL rstmid_recapture got=%h exp=%h", tx_frame, f); end
    wait_done(60, d, e, pr, gs);
    checks++; if (d !== exp) begin failures++; $display("FAIL rstmid_done got=%b exp=%b", d, exp); end
    checks++; if (mac_word() !== f) begin failures++; $display("FAIL rstmid_bytes got=%h exp=%h", mac_word(), f); end
    mac_bytes.delete();
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_contention();
    test_late_arrival();
    test_frame_stability();
    test_random();
    test_timeout();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, meaning the number of frame requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 16, meaning the cycles to wait for resp_active to rise (used only under TX_ARB_TIMEOUT_EN).
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, NUM_REQ, meaning per-requester frame-send request, held high until gnt.
REQ-006 The block SHALL have port req_frame, input, NUM_REQ x 128, meaning per-requester 16-byte frame, byte 15 in [127:120] sent first, stable while req is high.
REQ-007 The block SHALL have port gnt, output, NUM_REQ, meaning a one-hot 1-cycle pulse: frame captured, requester may drop req.
REQ-008 The block SHALL have port done, output, NUM_REQ, meaning a one-hot 1-cycle pulse: granted frame fully transmitted or aborted.
REQ-009 The block SHALL have port start_tx_req, output, 1, meaning the launch level to the TX MAC, which edge-detects it.
REQ-010 The block SHALL have port tx_frame, output, 128, meaning the captured frame presented to the TX MAC.
REQ-011 The block SHALL have port resp_active, input, 1, meaning TX MAC busy sending a frame.
REQ-012 The block SHALL have port busy, output, 1, meaning the arbiter is not in IDLE.
REQ-013 The block SHALL have port err_timeout, output, 1, meaning a 1-cycle pulse on launch timeout (tied 0 without TX_ARB_TIMEOUT_EN).

Function
REQ-014 The FSM SHALL have the states IDLE, LAUNCH, WAIT_ACTIVE and WAIT_DONE.
REQ-015 In IDLE with any req bit set, the block SHALL, in that cycle, select the winner round-robin, pulse gnt[winner], capture req_frame[winner] into tx_frame and the winner index, then go to LAUNCH.
REQ-016 Round-robin SHALL start the search at the requester after the last granted one (wrap NUM_REQ-1 -> 0); after reset the pointer favours requester 0.
REQ-017 LAUNCH SHALL last exactly one cycle with start_tx_req=1, then go to WAIT_ACTIVE; start_tx_req SHALL be 0 in every other state.
REQ-018 WAIT_ACTIVE SHALL go to WAIT_DONE on the first cycle with resp_active=1.
REQ-019 WAIT_DONE SHALL, on the first cycle with resp_active=0, pulse done[granted index] and return to IDLE, with a new grant possible on the next cycle.
REQ-020 tx_frame SHALL hold the captured value from the capture cycle until the next grant; req or req_frame changes after gnt SHALL have no effect.
REQ-021 Requests that arrive while busy SHALL wait; req SHALL NOT be sampled outside IDLE.
REQ-022 A request present on the same cycle that done fires SHALL be granted on the following IDLE cycle.
REQ-023 busy SHALL be 1 in LAUNCH, WAIT_ACTIVE and WAIT_DONE, and 0 in IDLE.

Reset
REQ-024 Asserting rst_n low SHALL force IDLE asynchronously, set the RR pointer to favour requester 0, and set gnt=0, done=0, start_tx_req=0, tx_frame=0, busy=0 and err_timeout=0, including mid-frame; no done SHALL be issued for an aborted frame.

Configuration
REQ-025 With macro TX_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_ACTIVE; if resp_active has stayed 0 for TIMEOUT_CYC cycles, the block SHALL pulse err_timeout and done[granted] together and return to IDLE.
REQ-026 Without TX_ARB_TIMEOUT_EN, WAIT_ACTIVE SHALL wait indefinitely, no counter SHALL be built, and err_timeout SHALL be constant 0.

Structure
REQ-027 Package uart_tx_arb_pkg SHALL hold the FSM state enum, FRAME_W=128 and the default for TIMEOUT_CYC.
REQ-028 The round-robin pointer/priority picker SHALL be a sub-module rr_arbiter (inputs: req, pointer; output: one-hot winner).

Verification
REQ-029 Single request: req=3'b010, frame 128'h00..0F (0x00 first, 0x0F last) -> gnt=3'b010 in the capture cycle, start_tx_req high exactly 1 cycle, MAC emits 0x00..0x0F, done=3'b010 one cycle after resp_active falls.
REQ-030 Contention: req=3'b111 held -> grant order 0,1,2,0; each done precedes the next gnt; start_tx_req never high on consecutive cycles.
REQ-031 Late arrival: req[2] rises during requester 0's frame -> no gnt until after done[0], then gnt=3'b100.
REQ-032 Frame stability: change req_frame[0] after gnt[0] -> transmitted bytes match the captured value.
REQ-033 Timeout (TX_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, MAC held idle): err_timeout and done[0] pulse together 16 cycles after LAUNCH; without the macro, busy stays 1.
REQ-034 Reset mid-frame: drop rst_n in WAIT_DONE -> all outputs 0 immediately; after release, req=3'b011 -> gnt=3'b001 first.
